mux_8x1_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 8:1 1-bit mux (mux_8x1_1bit) among

---
 rtl/mux_8x1_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux_8x1_rr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mux_8x1_rr_arbiter.sv
// ============================================================================
// Module   : mux_8x1_rr_arbiter
// Brief    : Round-robin arbiter steering a shared 8:1 1-bit mux. Produces
//            a registered mux select, a one-hot grant and a busy flag, and
//            bounds every grant to MAX_HOLD cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_8x1_rr_arbiter #(
  parameter int MAX_HOLD = 4,  // max cycles one grant is held, 1..8
  parameter int CNT_W    = 3   // hold-counter width, 2**CNT_W >= MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] S,
  output logic [7:0] gnt,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter value on which the current grant is forcibly released.
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       last_q, last_d;

  logic             w_release;
  logic [2:0]       w_pick_ptr;
  logic [2:0]       w_winner;

  // Search ptr+1, ptr+2, ... ptr+8 (mod 8); the first requesting index wins.
  // The last candidate is ptr itself, so a lone releaser can be re-granted.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Release test for the running grant; meaningful only in GRANT.
  always_comb begin
    w_release = (req[s_q] == 1'b0) || done || (cnt_q == C_HOLD_LAST);
  end

  // On release the pointer moves to the releaser in the same edge, so the
  // search must start from s_q rather than the not-yet-updated last_q.
  always_comb begin
    w_pick_ptr = (state_q == GRANT) ? s_q : last_q;
    w_winner   = rr_pick(req, w_pick_ptr);
  end

  // Next-state and next-output logic; everything holds by default.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req != 8'h00) begin
          state_d = GRANT;
          s_d     = w_winner;
          gnt_d   = 8'(1) << w_winner;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          last_d = s_q;
          if (req != 8'h00) begin
            s_d    = w_winner;
            gnt_d  = 8'(1) << w_winner;
            busy_d = 1'b1;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 at top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 3'd0;
      gnt_q   <= 8'h00;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 3'd7;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign S    = s_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_8x1_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux_8x1_rr_arbiter
// Brief    : Directed vector table, rotation / async-reset sequences and a
//            random invariant and starvation run for mux_8x1_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_8x1_rr_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 3;
  localparam int NVEC     = 25;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] S;
  logic [7:0] gnt;
  logic       busy;

  int checks;
  int errors;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
  } vec_t;

  vec_t vecs [NVEC];

  mux_8x1_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .S     (S),
    .gnt   (gnt),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    int         wait_cnt [8];
    int         idx;
    bit         seen;
    logic [7:0] g;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 8'hFF;
    done   = 1'b0;

    //             rst  req    done  gnt    S     busy
    vecs[0]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0}; // held in reset
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1}; // req 0 first
    vecs[2]  = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0}; // drop -> idle
    vecs[3]  = '{1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1}; // grant 3
    vecs[4]  = '{1'b1, 8'h28, 1'b0, 8'h08, 3'd3, 1'b1}; // cnt=1
    vecs[5]  = '{1'b1, 8'h28, 1'b1, 8'h20, 3'd5, 1'b1}; // done -> 5
    vecs[6]  = '{1'b1, 8'h28, 1'b0, 8'h20, 3'd5, 1'b1};
    vecs[7]  = '{1'b1, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1}; // 5 drops -> 3
    vecs[8]  = '{1'b1, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1}; // 3 drops -> 2
    vecs[9]  = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0}; // idle, S keeps 2
    vecs[10] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0};
    vecs[11] = '{1'b1, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1}; // 2 again alone
    vecs[12] = '{1'b1, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1}; // 2 drops -> 7
    vecs[13] = '{1'b1, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1}; // wrap -> 0
    vecs[14] = '{1'b1, 8'h81, 1'b1, 8'h80, 3'd7, 1'b1}; // back to 7
    vecs[15] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd7, 1'b0}; // idle
    vecs[16] = '{1'b1, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1}; // grant 1
    vecs[17] = '{1'b1, 8'h03, 1'b0, 8'h02, 3'd1, 1'b1}; // no preempt
    vecs[18] = '{1'b1, 8'h03, 1'b0, 8'h02, 3'd1, 1'b1};
    vecs[19] = '{1'b1, 8'h03, 1'b0, 8'h02, 3'd1, 1'b1}; // 4th cycle
    vecs[20] = '{1'b1, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1}; // hold limit -> 0
    vecs[21] = '{1'b1, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1};
    vecs[22] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0}; // idle
    vecs[23] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0}; // done ignored
    vecs[24] = '{1'b1, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1}; // grant 5

    // Reset state before any edge, with all requests pending.
    #1;
    check("reset_gnt",  32'(gnt),  32'h00);
    check("reset_S",    32'(S),    32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      done  = vecs[i].done;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_gnt", i),  32'(gnt),  32'(vecs[i].gnt));
      check($sformatf("vec%0d_S", i),    32'(S),    32'(vecs[i].s));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Full rotation with all requests held: 4 cycles each, 0..7 then 0.
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8 * MAX_HOLD + MAX_HOLD; c++) begin
      @(posedge clk);
      #1;
      idx = (c / MAX_HOLD) % 8;
      check($sformatf("rot%0d_gnt", c), 32'(gnt),  32'(8'(1) << idx));
      check($sformatf("rot%0d_S", c),   32'(S),    32'(idx));
      check($sformatf("rot%0d_busy", c), 32'(busy), 32'd1);
    end

    // Async reset between edges while requester 4 holds the grant.
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (gnt == 8'h10) seen = 1'b1;
    end
    check("wait_gnt_10", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt",  32'(gnt),  32'h00);
    check("async_busy", 32'(busy), 32'd0);
    check("async_S",    32'(S),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h00;

    // Random traffic: invariants and bounded waiting per requester.
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      done = ($urandom_range(7) == 0);
      @(posedge clk);
      #1;
      g = gnt;
      check("inv_onehot", 32'((g & (g - 8'd1)) == 8'h00), 32'd1);
      check("inv_busy",   32'(busy), 32'(|g));
      check("inv_gnt_S",  32'(g[S]), 32'(busy));
      for (int i = 0; i < 8; i++) begin
        if (req[i] && !g[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > 7 * MAX_HOLD) begin
          check($sformatf("starve_%0d", i), 32'(wait_cnt[i]), 32'(7 * MAX_HOLD));
          wait_cnt[i] = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
